// File: rtl/multicycle_sequencer.sv
// Cycle sequencer for the multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB with per-cycle strobes.
// Optional SEQ_PERF_COUNTERS_EN adds cycle_count/instr_count performance counters.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write_seq,
  output logic       pc_write_tgt,
  output logic       ab_write,
  output logic       alu_write,
  output logic       mem_req,
  output logic       mem_read_en,
  output logic       mem_write_en,
  output logic       rf_write1_en,
  output logic       rf_write2_en,
  output logic       instr_done,
  output logic       mem_err,
  output logic [2:0] state
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpLw    = 6'h05;
  localparam logic [5:0] OpLwPoi = 6'h06;
  localparam logic [5:0] OpSw    = 6'h07;
  localparam logic [5:0] OpJmp   = 6'h0C;
  localparam logic [5:0] OpCall  = 6'h0D;
  localparam logic [5:0] OpRet   = 6'h0E;
  localparam logic [5:0] OpPush  = 6'h0F;
  localparam logic [5:0] OpPop   = 6'h10;

  localparam logic [TO_W-1:0] TimeoutVal = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic is_alu, is_branch, is_illegal, is_mem_rd, is_mem_wr, is_load, is_pc_mem;
  logic ir_c, pcs_c, pct_c, ab_c, alu_c, req_c, rd_c, wr_c, rf1_c, rf2_c, done_c;

  assign is_alu     = (opcode <= 6'h04);
  assign is_branch  = (opcode >= 6'h08) && (opcode <= 6'h0B);
  assign is_illegal = (opcode >= 6'h11);
  assign is_mem_rd  = (opcode == OpLw) || (opcode == OpLwPoi) || (opcode == OpRet) ||
                      (opcode == OpPop);
  assign is_mem_wr  = (opcode == OpSw) || (opcode == OpCall) || (opcode == OpPush);
  assign is_load    = (opcode == OpLw) || (opcode == OpLwPoi) || (opcode == OpPop);
  assign is_pc_mem  = (opcode == OpCall) || (opcode == OpRet);

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = '0;
    mem_err_d = mem_err_q;
    ir_c      = 1'b0;
    pcs_c     = 1'b0;
    pct_c     = 1'b0;
    ab_c      = 1'b0;
    alu_c     = 1'b0;
    req_c     = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    rf1_c     = 1'b0;
    rf2_c     = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      StFetch: begin
        if (run) begin
          ir_c    = 1'b1;
          pcs_c   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (opcode == OpJmp) begin
          ab_c    = 1'b1;
          pct_c   = 1'b1;
          done_c  = 1'b1;
          state_d = StFetch;
        end else if (is_illegal) begin
          // Illegal opcodes retire as a NOP without touching any datapath latch.
          done_c  = 1'b1;
          state_d = StFetch;
        end else begin
          ab_c    = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        alu_c = 1'b1;
        if (is_alu) begin
          state_d = StWb;
        end else if (is_branch) begin
          pct_c   = branch_taken;
          done_c  = 1'b1;
          state_d = StFetch;
        end else if (is_mem_rd || is_mem_wr) begin
          state_d = StMem;
        end else begin
          done_c  = 1'b1;
          state_d = StFetch;
        end
      end
      StMem: begin
        req_c = 1'b1;
        rd_c  = is_mem_rd;
        wr_c  = is_mem_wr;
        if (mem_ready) begin
          if (is_load) begin
            state_d = StWb;
          end else begin
            pct_c   = is_pc_mem;
            done_c  = 1'b1;
            state_d = StFetch;
          end
        end else if ((MEM_TIMEOUT != 0) && (to_cnt_q == TimeoutVal)) begin
          mem_err_d = 1'b1;
          done_c    = 1'b1;
          state_d   = StFetch;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      StWb: begin
        rf1_c   = 1'b1;
        rf2_c   = (opcode == OpLwPoi) || (opcode == OpPop);
        done_c  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Every output is held low while reset is asserted, even mid-instruction.
  assign ir_write     = rst_n & ir_c;
  assign pc_write_seq = rst_n & pcs_c;
  assign pc_write_tgt = rst_n & pct_c;
  assign ab_write     = rst_n & ab_c;
  assign alu_write    = rst_n & alu_c;
  assign mem_req      = rst_n & req_c;
  assign mem_read_en  = rst_n & rd_c;
  assign mem_write_en = rst_n & wr_c;
  assign rf_write1_en = rst_n & rf1_c;
  assign rf_write2_en = rst_n & rf2_c;
  assign instr_done   = rst_n & done_c;
  assign mem_err      = rst_n & mem_err_q;
  assign state        = rst_n ? state_q : 3'd0;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, instr_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      if (!((state_q == StFetch) && !run)) cycle_count_q <= cycle_count_q + 32'd1;
      if (done_c) instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: per-cycle expected output vectors are queued with
// their stimulus, then replayed and compared cycle by cycle.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write_seq, pc_write_tgt, ab_write, alu_write, mem_req;
  logic       mem_read_en, mem_write_en, rf_write1_en, rf_write2_en, instr_done, mem_err;
  logic [2:0] state;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_count;
`endif

  multicycle_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .ir_write     (ir_write),
    .pc_write_seq (pc_write_seq),
    .pc_write_tgt (pc_write_tgt),
    .ab_write     (ab_write),
    .alu_write    (alu_write),
    .mem_req      (mem_req),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .rf_write1_en (rf_write1_en),
    .rf_write2_en (rf_write2_en),
    .instr_done   (instr_done),
    .mem_err      (mem_err),
    .state        (state)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .cycle_count  (cycle_count),
    .instr_count  (instr_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [11:0] IR   = 12'h800;
  localparam logic [11:0] PCS  = 12'h400;
  localparam logic [11:0] PCT  = 12'h200;
  localparam logic [11:0] AB   = 12'h100;
  localparam logic [11:0] ALU  = 12'h080;
  localparam logic [11:0] REQ  = 12'h040;
  localparam logic [11:0] RD   = 12'h020;
  localparam logic [11:0] WR   = 12'h010;
  localparam logic [11:0] RF1  = 12'h008;
  localparam logic [11:0] RF2  = 12'h004;
  localparam logic [11:0] DONE = 12'h002;
  localparam logic [11:0] ERR  = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  typedef struct {
    logic        run;
    logic        mr;
    logic        bt;
    logic        rn;
    logic [14:0] exp;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad = 0;

  function automatic void put(input logic r, input logic mr, input logic bt, input logic rn,
                              input logic [14:0] exp);
    rec_t e;
    e.run = r;
    e.mr  = mr;
    e.bt  = bt;
    e.rn  = rn;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  // Drive one cycle's inputs, sample the settled outputs, then advance past the next edge.
  task automatic cyc(input logic r, input logic mr, input logic bt, input logic rn,
                     output logic [14:0] o);
    run          = r;
    mem_ready    = mr;
    branch_taken = bt;
    rst_n        = rn;
    #1;
    o = {state, ir_write, pc_write_seq, pc_write_tgt, ab_write, alu_write, mem_req,
         mem_read_en, mem_write_en, rf_write1_en, rf_write2_en, instr_done, mem_err};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    put(1, 1, 1, 0, {3'd0, NONE});
    put(1, 1, 1, 0, {3'd0, NONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL reset c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_alu();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h01;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(1, 0, 0, 1, {3'd1, AB});
    put(1, 0, 0, 1, {3'd2, ALU});
    put(0, 0, 0, 1, {3'd4, RF1 | DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL alu c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_load();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h05;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(1, 0, 0, 1, {3'd1, AB});
    put(1, 0, 0, 1, {3'd2, ALU});
    for (int i = 0; i < 3; i++) put(1, 0, 0, 1, {3'd3, REQ | RD});
    put(1, 1, 0, 1, {3'd3, REQ | RD});
    put(0, 0, 0, 1, {3'd4, RF1 | DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL load_lw c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
    n = 0;
    opcode = 6'h10;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(0, 1, 0, 1, {3'd1, AB});
    put(0, 1, 0, 1, {3'd2, ALU});
    put(0, 1, 0, 1, {3'd3, REQ | RD});
    put(0, 0, 0, 1, {3'd4, RF1 | RF2 | DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL load_pop c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h0A;
    put(1, 1, 1, 1, {3'd0, IR | PCS});
    put(1, 1, 1, 1, {3'd1, AB});
    put(1, 1, 1, 1, {3'd2, ALU | PCT | DONE});
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(1, 0, 0, 1, {3'd1, AB});
    put(1, 0, 0, 1, {3'd2, ALU | DONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL branch c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
    n = 0;
    opcode = 6'h0C;
    put(1, 0, 1, 1, {3'd0, IR | PCS});
    put(1, 0, 1, 1, {3'd1, AB | PCT | DONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL jmp c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
    n = 0;
    opcode = 6'h20;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(0, 0, 0, 1, {3'd1, DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL illegal c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h07;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(0, 0, 0, 1, {3'd1, AB});
    put(0, 0, 0, 1, {3'd2, ALU});
    for (int i = 0; i < 15; i++) put(0, 0, 0, 1, {3'd3, REQ | WR});
    put(0, 0, 0, 1, {3'd3, REQ | WR | DONE});
    put(0, 1, 0, 1, {3'd0, ERR});
    put(0, 0, 0, 1, {3'd0, ERR});
    put(0, 1, 0, 0, {3'd0, NONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL timeout_sw c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
    // PUSH whose mem_ready lands on the exact timeout cycle completes normally.
    n = 0;
    opcode = 6'h0F;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(0, 0, 0, 1, {3'd1, AB});
    put(0, 0, 0, 1, {3'd2, ALU});
    for (int i = 0; i < 15; i++) put(0, 0, 0, 1, {3'd3, REQ | WR});
    put(0, 1, 0, 1, {3'd3, REQ | WR | DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL timeout_edge c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h06;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(1, 0, 0, 1, {3'd1, AB});
    put(1, 0, 0, 1, {3'd2, ALU});
    put(1, 0, 0, 1, {3'd3, REQ | RD});
    put(1, 1, 0, 0, {3'd0, NONE});
    put(0, 1, 0, 1, {3'd0, NONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL reset_mid c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    rec_t        e;
    logic [14:0] o;
    int          n = 0;
    opcode = 6'h0D;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(0, 0, 0, 1, {3'd1, AB});
    put(0, 0, 0, 1, {3'd2, ALU});
    put(0, 0, 0, 1, {3'd3, REQ | WR});
    put(0, 1, 0, 1, {3'd3, REQ | WR | PCT | DONE});
    for (int i = 0; i < 3; i++) put(0, 1, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL call c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
    n = 0;
    opcode = 6'h0E;
    put(1, 0, 0, 1, {3'd0, IR | PCS});
    put(1, 0, 0, 1, {3'd1, AB});
    put(1, 0, 0, 1, {3'd2, ALU});
    put(1, 1, 0, 1, {3'd3, REQ | RD | PCT | DONE});
    put(0, 0, 0, 1, {3'd0, NONE});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cyc(e.run, e.mr, e.bt, e.rn, o);
      total++;
      if (o !== e.exp) begin
        bad++;
        $display("FAIL ret c%0d got=%h want=%h", n, o, e.exp);
      end
      n++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
